// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, mode/state encodings and window length helper for adc_capture
package adc_pkg;

  localparam int ADC_W = 8;
  localparam int RAW_W = 12;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_AVG4   = 2'b01,
    MODE_SUM16  = 2'b10,
    MODE_PEAK16 = 2'b11
  } adc_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_ACCUM = 2'b10
  } adc_state_t;

  function automatic logic [4:0] window_len(adc_mode_t m);
    case (m)
      MODE_PASS: window_len = 5'd1;
      MODE_AVG4: window_len = 5'd4;
      default:   window_len = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/adc_clkgen.sv
// rtl/adc_clkgen.sv - ADC conversion clock divider and mid-low-phase sample strobe
module adc_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_fast,
  input  logic rst,
  input  logic run,
  output logic adc_clk,
  output logic strobe
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             running;

  assign div_nxt = (div_cnt == LAST) ? '0 : div_cnt + DIV_W'(1);

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
      running <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
      running <= 1'b0;
    end else if (!running) begin
      // Leaving idle: hold phase 0 one cycle so the first high phase is full length.
      div_cnt <= '0;
      adc_clk <= 1'b1;
      running <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      adc_clk <= (div_nxt < HALF);
    end
  end

  assign strobe = run && running && (div_cnt == HALF);

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - ADC capture FSM: pipeline priming, windowed decimation to 12-bit results
module adc_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int ADC_PIPE = 3
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [ADC_W-1:0] adc_din,
  output logic             adc_clk,
  output logic [RAW_W-1:0] raw_out,
  output logic             raw_valid,
  output logic             overrange
);

  localparam int PW = $clog2(ADC_PIPE + 1);

  adc_state_t       state;
  logic [PW-1:0]    prime_cnt;
  logic [3:0]       samp_cnt;
  logic [RAW_W-1:0] acc;
  logic [RAW_W-1:0] acc_nxt;
  logic [RAW_W-1:0] result;
  adc_mode_t        cur_mode;
  adc_mode_t        eff_mode;
  logic [4:0]       win_len;
  logic             ovr_acc;
  logic             ovr_nxt;
  logic             first;
  logic             last;
  logic             strobe;

  adc_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_fast (clk_fast),
    .rst      (rst),
    .run      (enable),
    .adc_clk  (adc_clk),
    .strobe   (strobe)
  );

  // The mode in force is sampled live on the first strobe of a window, latched afterwards.
  always_comb begin
    first    = (samp_cnt == 4'd0);
    eff_mode = first ? adc_mode_t'(mode) : cur_mode;
    win_len  = window_len(eff_mode);
    last     = ({1'b0, samp_cnt} == win_len - 5'd1);
    ovr_nxt  = (adc_din == '0) || (adc_din == '1) || (!first && ovr_acc);
    if (first)
      acc_nxt = RAW_W'(adc_din);
    else if (eff_mode == MODE_PEAK16)
      acc_nxt = (RAW_W'(adc_din) > acc) ? RAW_W'(adc_din) : acc;
    else
      acc_nxt = acc + RAW_W'(adc_din);
    case (eff_mode)
      MODE_AVG4:  result = {acc_nxt[9:0], 2'b00};
      MODE_SUM16: result = acc_nxt;
      default:    result = {acc_nxt[7:0], 4'h0};
    endcase
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      prime_cnt <= '0;
      samp_cnt  <= '0;
      acc       <= '0;
      cur_mode  <= MODE_PASS;
      ovr_acc   <= 1'b0;
      raw_out   <= '0;
      raw_valid <= 1'b0;
      overrange <= 1'b0;
    end else begin
      raw_valid <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
            samp_cnt  <= '0;
          end
          ST_PRIME: begin
            if (strobe) begin
              if (prime_cnt == PW'(ADC_PIPE - 1)) begin
                state    <= ST_ACCUM;
                samp_cnt <= '0;
              end else begin
                prime_cnt <= prime_cnt + PW'(1);
              end
            end
          end
          ST_ACCUM: begin
            if (strobe) begin
              acc     <= acc_nxt;
              ovr_acc <= ovr_nxt;
              if (first)
                cur_mode <= eff_mode;
              if (last) begin
                raw_out   <= result;
                overrange <= ovr_nxt;
                raw_valid <= 1'b1;
                samp_cnt  <= '0;
              end else begin
                samp_cnt <= samp_cnt + 4'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/adc_capture.md
# adc_capture

Synchronous ADC capture controller: the receive-side counterpart of the DAC controller. It generates the conversion clock for an external 8-bit pipelined parallel ADC and discards the ADC's pipeline-priming samples. It then decimates 8-bit samples into a 12-bit internal-resolution result with a one-cycle valid strobe. It sits between the ADC pins and the 12-bit internal datapath, in the same `clk_fast` domain as the DAC side.

## Interface
- `CLK_DIV`, 4: `clk_fast` cycles per ADC clock period; even, ≥2.
- `ADC_PIPE`, 3: ADC conversion latency in ADC clocks; strobes discarded after enable.
- `clk_fast`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  capture enable.
- `mode`  in  2  decimation mode (see Operation).
- `adc_din`  in  8  ADC parallel data, unsigned.
- `adc_clk`  out  1  ADC conversion clock.
- `raw_out`  out  12  decimated result, unsigned.
- `raw_valid`  out  1  one-cycle pulse per new `raw_out`.
- `overrange`  out  1  last window contained a sample of 0x00 or 0xFF.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 while enabled.
  - `adc_clk` is registered: high while `div_cnt` < CLK_DIV/2, else low.
  - Sample strobe fires when `div_cnt` == CLK_DIV/2, i.e. mid-low phase. `adc_din` is registered on that strobe only.
- States:
  - IDLE: `adc_clk` low, `div_cnt` 0. Enable rising → PRIME.
  - PRIME: count ADC_PIPE strobes, discarding the data. → ACCUM.
  - ACCUM: accumulate samples per the mode latched at window start. At the end of the window, emit the result and start the next window immediately, with no gap strobe.
  - Enable low in any state → IDLE next cycle. The partial window is discarded with no `raw_valid`; `raw_out` and `overrange` hold.
- Modes, latched at the first strobe of each window. A `mode` change mid-window affects only the next window.
  - 00: 1 sample, result = s<<4.
  - 01: 4 samples, 10-bit sum<<2.
  - 10: 16 samples, 12-bit sum, no shift, no saturation possible.
  - 11: 16 samples, peak hold, result = max<<4.
- Accumulator is 12 bits and is cleared at window start (first sample loaded, not added).
- `overrange` is updated with `raw_out`: it is the OR over the window of (s==0x00 | s==0xFF).

## Timing
- Reset values: `adc_clk` 0, `raw_out` 0, `raw_valid` 0, `overrange` 0, state IDLE, counters 0. Reset is effective mid-operation with no completion of the current window.
- Enable→first strobe: CLK_DIV/2+1 cycles (one cycle to leave IDLE).
- First valid result: after ADC_PIPE + N strobes, where N is the window length.
- `raw_valid` is asserted the cycle after the last strobe of the window. `raw_out`/`overrange` change in that same cycle and hold until the next valid.
- Valid rate: one per N·CLK_DIV cycles.
- Enable deasserted in the same cycle as the final strobe: the strobe is ignored and no valid is produced.

## Structure
- Package `adc_pkg`:
  - mode encodings (`MODE_PASS`, `MODE_AVG4`, `MODE_SUM16`, `MODE_PEAK16`)
  - state enum
  - widths `ADC_W`=8, `RAW_W`=12
  - `window_len(mode)` function
- Sub-module `adc_clkgen`: divider, `adc_clk` register, strobe output; inputs `clk_fast`, `rst`, `run`.
- Top: FSM, prime counter, sample counter, accumulator/peak, output registers.

## Test plan
- CLK_DIV=4, ADC_PIPE=3, mode 00, `adc_din` constant 0xA5:
  - first 3 strobes produce no valid;
  - then `raw_out`=0xA50 with `raw_valid` every 4 cycles;
  - `overrange`=0.
- Mode 01, samples 0x10,0x20,0x30,0x40 → `raw_out`=0x280. Switching `mode` to 10 on the 2nd sample still yields 0x280 for that window.
- Mode 10, 16 samples of 0xFF → `raw_out`=0xFF0, `overrange`=1. Next window of 0x80 → 0x800, `overrange`=0.
- Mode 11, samples 0x01..0x10 in ascending order → `raw_out`=0x100, `overrange`=0.
- Mode 10, `enable` dropped after 7 samples:
  - no `raw_valid`, `adc_clk` low within 1 cycle, `raw_out` unchanged;
  - re-enable discards 3 strobes before accumulating again.
- `rst` pulsed mid-window (asynchronous, between clock edges) → all outputs 0 immediately, state IDLE. Capture resumes only with `enable` high after `rst` falls.
